// File: rtl/daq_pkg.sv
// daq_pkg: shared FSM type and sample width constants for the DAQ sampler.
package daq_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_DRDY, START, BUSY, DRAIN} state_t;
    localparam logic [7:0] CMD_RDATA_DEFAULT = 8'h01;
    localparam int RX_W = 24;
    localparam int SAMPLE_W = 32;
    localparam int SEQ_W = 8;
endpackage

// File: rtl/daq_fifo.sv
// daq_fifo: first-word-fall-through sample FIFO; head reads as zero when empty.
module daq_fifo import daq_pkg::*; #(
    parameter int WIDTH = SAMPLE_W + SEQ_W,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clock_i or negedge reset_ni)
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clock_i)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/daq_sampler.sv
// daq_sampler: drdy-triggered ADC read sequencer feeding a tagged sample FIFO.
module daq_sampler import daq_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] CMD_RDATA = CMD_RDATA_DEFAULT,
    parameter int SPI_TIMEOUT = 4096
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                enable_i,
    input  logic                drdy_ni,
    output logic                spi_start_o,
    output logic [7:0]          spi_tx_byte_o,
    input  logic                spi_done_i,
    input  logic [RX_W-1:0]     spi_rx_data_i,
    output logic [SAMPLE_W-1:0] sample_data_o,
    output logic [SEQ_W-1:0]    sample_seq_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output logic                overflow_o,
    output logic                timeout_o
);
    localparam int CW = SPI_TIMEOUT > 1 ? $clog2(SPI_TIMEOUT) : 1;
    state_t state;
    logic [2:0] drdy_sync;
    logic done_q, enable_q, full, empty, push, pop, accept, drdy_event, en_rise;
    logic [CW-1:0] cnt;
    logic [SEQ_W-1:0] seq;
    logic [SAMPLE_W+SEQ_W-1:0] wdata, head;
    // drdy_sync[1:0] is the synchronizer; drdy_sync[2] holds the previous synchronized level
    assign drdy_event = drdy_sync[2] & ~drdy_sync[1];
    assign en_rise = enable_i & ~enable_q;
    assign push = state == BUSY && spi_done_i && !done_q;
    assign pop = sample_valid_o & sample_ready_i;
    assign accept = push & (~full | pop);
    assign wdata = {{(SAMPLE_W-RX_W){spi_rx_data_i[RX_W-1]}}, spi_rx_data_i, seq};
    assign spi_tx_byte_o = CMD_RDATA;
    assign sample_valid_o = ~empty;
    assign {sample_data_o, sample_seq_o} = head;
    daq_fifo #(.WIDTH(SAMPLE_W + SEQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i(clock_i), .reset_ni(reset_ni), .push(accept), .wdata(wdata),
        .pop(pop), .rdata(head), .full(full), .empty(empty)
    );
    always_ff @(posedge clock_i or negedge reset_ni)
        if (!reset_ni) begin
            state <= IDLE;
            drdy_sync <= '1;
            done_q <= 1'b0;
            enable_q <= 1'b0;
            cnt <= '0;
            seq <= '0;
            spi_start_o <= 1'b0;
            overflow_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            drdy_sync <= {drdy_sync[1:0], drdy_ni};
            done_q <= spi_done_i;
            enable_q <= enable_i;
            spi_start_o <= 1'b0;
            if (accept) seq <= seq + 1'b1;
            overflow_o <= (overflow_o & ~en_rise) | (push & ~accept);
            if (en_rise) timeout_o <= 1'b0;
            case (state)
                IDLE: if (enable_i) state <= WAIT_DRDY;
                WAIT_DRDY:
                    if (!enable_i) state <= IDLE;
                    else if (drdy_event) begin
                        state <= START;
                        spi_start_o <= 1'b1;
                    end
                START: begin
                    cnt <= '0;
                    state <= BUSY;
                end
                BUSY:
                    if (push) state <= DRAIN;
                    else if (cnt == CW'(SPI_TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        state <= DRAIN;
                    end else cnt <= cnt + 1'b1;
                DRAIN: if (!spi_done_i) state <= enable_i ? WAIT_DRDY : IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_daq_sampler.sv
// tb_daq_sampler: directed and randomized checks against a queue-based sample model.
module tb_daq_sampler;
    localparam int DEPTH = 4;
    localparam int TMO = 400;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, drdy_n = 1'b1, done = 1'b0, ready = 1'b0;
    logic [23:0] rx = '0;
    logic spi_start, valid, ovf, tmo;
    logic [7:0] tx_byte, seq_o;
    logic [31:0] data_o;
    int checks = 0, passes = 0;
    logic [39:0] q[$];
    logic [7:0] seq_m = '0;
    bit ovf_m, to_m, push_m, to_set_m, en_prev, rand_ready;

    daq_sampler #(.FIFO_DEPTH(DEPTH), .SPI_TIMEOUT(TMO)) dut (
        .clock_i(clk), .reset_ni(reset_n), .enable_i(enable), .drdy_ni(drdy_n),
        .spi_start_o(spi_start), .spi_tx_byte_o(tx_byte), .spi_done_i(done),
        .spi_rx_data_i(rx), .sample_data_o(data_o), .sample_seq_o(seq_o),
        .sample_valid_o(valid), .sample_ready_i(ready), .overflow_o(ovf), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [39:0] entry(input logic [23:0] r, input logic [7:0] s);
        logic signed [31:0] v;
        v = $signed(r);
        return {v, s};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: model the FIFO/flag effects of this edge, then compare at the next negedge.
    task automatic cyc();
        bit pop_m, rise_m;
        if (rand_ready) ready = $urandom_range(0, 3) == 0;
        pop_m = q.size() > 0 && ready;
        rise_m = enable && !en_prev;
        @(posedge clk);
        en_prev = enable;
        if (pop_m) void'(q.pop_front());
        if (rise_m) begin ovf_m = 0; to_m = 0; end
        if (push_m) begin
            if (q.size() < DEPTH) begin q.push_back(entry(rx, seq_m)); seq_m++; end
            else ovf_m = 1;
            push_m = 0;
        end
        if (to_set_m) begin to_m = 1; to_set_m = 0; end
        @(negedge clk);
        chk("valid", valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("head_data", data_o, q[0][39:8]);
            chk("head_seq", seq_o, q[0][7:0]);
        end
        chk("overflow", ovf, ovf_m);
        chk("timeout", tmo, to_m);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; ready = 1'b0; done = 1'b0; drdy_n = 1'b1; rx = '0;
        q.delete(); seq_m = '0; ovf_m = 0; to_m = 0; push_m = 0; to_set_m = 0; en_prev = 0; rand_ready = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic begin_txn(output bit got);
        got = 0;
        drdy_n = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin cyc(); got = spi_start; end
        chk("start_seen", got, 1'b1);
        drdy_n = 1'b1;
        if (got) begin cyc(); chk("start_width", spi_start, 1'b0); end
    endtask

    task automatic finish_txn(input logic [23:0] r, input int dly);
        repeat (dly) cyc();
        rx = r; done = 1'b1; push_m = 1; cyc();
        rx = 24'($urandom);
        cyc();
        done = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic transact(input logic [23:0] r, input int dly);
        bit got;
        begin_txn(got);
        if (got) finish_txn(r, dly);
    endtask

    initial begin
        bit got;
        int starts;
        @(negedge clk);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_tx", tx_byte, 8'h01);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_seq", seq_o, 8'h0);
        chk("rst_flags", {ovf, tmo}, 2'b00);

        // positive full-scale sample after a long conversion
        do_reset(); enable = 1'b1; repeat (3) cyc();
        transact(24'h7FFFFF, 300);
        chk("pos_data", data_o, 32'h007FFFFF);
        chk("pos_seq", seq_o, 8'h00);

        // sign extension of negative samples
        do_reset(); enable = 1'b1; repeat (3) cyc();
        transact(24'h800000, 5);
        transact(24'hFFFFFF, 7);
        chk("neg_data0", data_o, 32'hFF800000);
        chk("neg_seq0", seq_o, 8'h00);
        ready = 1'b1; cyc(); ready = 1'b0;
        chk("neg_data1", data_o, 32'hFFFFFFFF);
        chk("neg_seq1", seq_o, 8'h01);

        // overflow with a stalled consumer, then in-order drain and flag clear
        do_reset(); enable = 1'b1; repeat (3) cyc();
        for (int i = 0; i < 5; i++) transact(24'($urandom), 3 + i);
        chk("ovf_set", ovf, 1'b1);
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin chk("drain_seq", seq_o, 8'(i)); cyc(); end
        chk("drained", valid, 1'b0);
        chk("ovf_sticky", ovf, 1'b1);
        ready = 1'b0;
        enable = 1'b0; cyc(); enable = 1'b1; cyc();
        chk("ovf_clear", ovf, 1'b0);

        // SPI never completes
        do_reset(); enable = 1'b1; repeat (3) cyc();
        begin_txn(got);
        repeat (TMO - 1) cyc();
        chk("to_before", tmo, 1'b0);
        to_set_m = 1; cyc();
        chk("to_after", tmo, 1'b1);
        chk("to_empty", valid, 1'b0);
        repeat (3) cyc();
        transact(24'h000123, 4);
        chk("to_next_data", data_o, 32'h00000123);
        chk("to_next_seq", seq_o, 8'h00);

        // enable dropped mid-transaction still completes, then stays idle
        do_reset(); enable = 1'b1; repeat (3) cyc();
        begin_txn(got);
        enable = 1'b0;
        finish_txn(24'h123456, 6);
        chk("drop_data", data_o, 32'h00123456);
        starts = 0;
        for (int k = 0; k < 3; k++) begin
            drdy_n = 1'b0; repeat (6) begin cyc(); starts += int'(spi_start); end
            drdy_n = 1'b1; repeat (6) begin cyc(); starts += int'(spi_start); end
        end
        chk("idle_no_start", starts, 0);

        // asynchronous reset during BUSY
        do_reset(); enable = 1'b1; repeat (3) cyc();
        transact(24'h0000AA, 2);
        begin_txn(got);
        repeat (10) cyc();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", valid, 1'b0);
        chk("arst_data", data_o, 32'h0);
        chk("arst_seq", seq_o, 8'h0);
        chk("arst_start", spi_start, 1'b0);
        chk("arst_tx", tx_byte, 8'h01);
        q.delete(); seq_m = '0; ovf_m = 0; to_m = 0; en_prev = 0;
        @(negedge clk); reset_n = 1'b1;
        starts = 0;
        repeat (3) begin cyc(); starts += int'(spi_start); end
        rx = 24'h555555; done = 1'b1;
        repeat (3) begin cyc(); starts += int'(spi_start); end
        done = 1'b0;
        repeat (10) begin cyc(); starts += int'(spi_start); end
        chk("arst_no_push", valid, 1'b0);
        chk("arst_no_start", starts, 0);

        // randomized traffic with a random-ready consumer
        do_reset(); enable = 1'b1; rand_ready = 1; repeat (3) cyc();
        for (int i = 0; i < 30; i++) transact(24'($urandom), $urandom_range(0, 15));
        rand_ready = 0; ready = 1'b1;
        repeat (DEPTH + 1) cyc();
        chk("rand_empty", valid, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/daq_sampler.md
DAQ_SAMPLER -- requirements
Module: daq_sampler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, sample FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have parameter CMD_RDATA, default 8'h01, command byte sent to the ADC per sample.
REQ-003 SHALL have parameter SPI_TIMEOUT, default 4096, max cycles from spi_start_o to the spi_done_i rising edge.
REQ-004 clock_i  in  1  sole clock; all logic on posedge.
REQ-005 reset_ni  in  1  asynchronous, active-low reset.
REQ-006 enable_i  in  1  level; 1 = acquire continuously.
REQ-007 drdy_ni  in  1  ADC data-ready, active-low, asynchronous to clock_i.
REQ-008 spi_start_o  out  1  one-cycle start pulse to SPI master.
REQ-009 spi_tx_byte_o  out  8  command byte to SPI master; constant CMD_RDATA.
REQ-010 spi_done_i  in  1  SPI master done level.
REQ-011 spi_rx_data_i  in  24  SPI master receive buffer, two's complement.
REQ-012 sample_data_o  out  32  FIFO head: sign-extended sample.
REQ-013 sample_seq_o  out  8  FIFO head: sequence tag.
REQ-014 sample_valid_o  out  1  FIFO non-empty.
REQ-015 sample_ready_i  in  1  consumer accepts head when valid.
REQ-016 overflow_o  out  1  sticky: a sample was dropped.
REQ-017 timeout_o  out  1  sticky: SPI transaction timed out.

Function
REQ-018 drdy_ni SHALL pass a 2-flop synchronizer (reset value 1); a "drdy event" SHALL be a synchronized 1->0 transition.
REQ-019 FSM states SHALL be IDLE, WAIT_DRDY, START, BUSY, DRAIN.
REQ-020 IDLE -> WAIT_DRDY when enable_i=1; else stay.
REQ-021 WAIT_DRDY -> START on drdy event; -> IDLE if enable_i=0; events outside WAIT_DRDY SHALL be ignored.
REQ-022 START SHALL assert spi_start_o for exactly one cycle, clear the timeout counter, and go to BUSY.
REQ-023 BUSY SHALL detect a spi_done_i 0->1 edge; on that cycle capture spi_rx_data_i, push to FIFO, go to DRAIN.
REQ-024 BUSY SHALL count cycles; at SPI_TIMEOUT with no edge, set timeout_o, push nothing, go to DRAIN.
REQ-025 DRAIN SHALL wait for spi_done_i=0, then go to WAIT_DRDY if enable_i=1, else IDLE.
REQ-026 enable_i deassert in START/BUSY/DRAIN SHALL NOT abort; the transaction completes and its sample is pushed.
REQ-027 Pushed data SHALL be {{8{rx[23]}}, rx[23:0]} with tag = 8-bit sequence counter, incremented per accepted push, wrapping 8'hFF -> 8'h00.
REQ-028 FIFO SHALL be first-word-fall-through; pop occurs when sample_valid_o & sample_ready_i.
REQ-029 Push while full SHALL drop the sample, set overflow_o, not advance the sequence counter; if a pop occurs the same cycle, the push SHALL succeed.
REQ-030 Simultaneous push and pop at any other occupancy SHALL leave occupancy unchanged.
REQ-031 overflow_o and timeout_o SHALL clear only on the rising edge of enable_i or reset.

Reset
REQ-032 reset_ni=0 SHALL asynchronously force state IDLE, FIFO empty, sequence counter 0, synchronizer 1s, all outputs 0 except spi_tx_byte_o=CMD_RDATA.
REQ-033 Reset asserted mid-transaction SHALL discard the in-flight sample; no pulse or push follows release until a new drdy event.

Structure
REQ-034 Package daq_pkg SHALL hold the FSM state enum, the default CMD_RDATA value, and the sample width constants (24, 32, 8).
REQ-035 FIFO SHALL be a sub-module daq_fifo parameterized by width (40) and depth.

Verification
REQ-036 enable=1, drdy falls, done rises after 300 cycles with rx=24'h7FFFFF -> one spi_start_o pulse; head 32'h007FFFFF, seq 0.
REQ-037 rx=24'h800000 then 24'hFFFFFF -> heads 32'hFF800000 (seq 0), 32'hFFFFFFFF (seq 1).
REQ-038 ready=0, 5 samples, FIFO_DEPTH 4 -> 4 entries with seq 0..3, overflow_o=1; raising ready drains them in order.
REQ-039 done never rises -> timeout_o=1 at SPI_TIMEOUT cycles after start, FIFO empty, next drdy event starts a new transaction.
REQ-040 enable dropped during BUSY -> sample still pushed, FSM reaches IDLE after done falls, later drdy events give no start.
REQ-041 reset_ni pulsed low during BUSY -> all outputs at reset values immediately, no push after release.
